// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter controller: FSM state encoding and run modes.
package counter_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN_UP,
    RUN_DOWN,
    DONE
  } state_t;

  localparam logic [1:0] MODE_ONESHOT     = 2'b00;
  localparam logic [1:0] MODE_REPEAT      = 2'b01;
  localparam logic [1:0] MODE_BOUNCE      = 2'b10;
  localparam logic [1:0] MODE_BOUNCE_ONCE = 2'b11;

  // True in the two states where the prescaler free-runs and stop is honoured.
  function automatic logic is_run(input state_t s);
    return (s == RUN_UP) || (s == RUN_DOWN);
  endfunction

endpackage

// File: rtl/counter_tick_gen.sv
// Prescaler: step_due once every div+1 cycles while free-running; load pins it at div.
module counter_tick_gen #(
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [DIVW-1:0] div,
  output logic            step_due
);

  logic [DIVW-1:0] presc;

  assign step_due = (presc == '0);

  // Down-counter that reloads on expiry or while held by load.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (load || step_due) begin
      presc <= div;
    end else begin
      presc <= presc - 1'b1;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Run controller for an external up/down counter: clears it, paces its steps
// through the prescaler and turns around / wraps / finishes at the terminal count.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int BITS = 4,
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic [1:0]      mode,
  input  logic [BITS-1:0] limit,
  input  logic [DIVW-1:0] div,
  input  logic [BITS-1:0] cnt_val,
  output logic            cnt_en,
  output logic            cnt_up,
  output logic            cnt_clr,
  output logic            busy,
  output logic            done,
  output logic            wrap
);

  state_t          state;
  logic [1:0]      mode_q;
  logic [BITS-1:0] limit_q;
  logic [DIVW-1:0] div_q;
  logic            step_due;
  logic            at_limit;
  logic            at_zero;

  assign at_limit = (cnt_val == limit_q);
  assign at_zero  = (cnt_val == '0);

  // Prescaler is held at the latched div except while a run is stepping.
  counter_tick_gen #(.DIVW(DIVW)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (!is_run(state)),
    .div      (div_q),
    .step_due (step_due)
  );

  // State sequencing plus capture of the run configuration at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= '0;
      limit_q <= '0;
      div_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CLEAR;
            mode_q  <= mode;
            limit_q <= limit;
            div_q   <= div;
          end
        end
        CLEAR: state <= RUN_UP;
        RUN_UP: begin
          if (stop) begin
            state <= IDLE;
          end else if (step_due && at_limit) begin
            case (mode_q)
              MODE_ONESHOT: state <= DONE;
              MODE_REPEAT:  state <= RUN_UP;
              default:      state <= RUN_DOWN;
            endcase
          end
        end
        RUN_DOWN: begin
          if (stop) begin
            state <= IDLE;
          end else if (step_due && at_zero) begin
            state <= (mode_q == MODE_BOUNCE) ? RUN_UP : DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Counter controls decoded from the registered state, prescaler and feedback.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    cnt_en  = 1'b0;
    cnt_up  = 1'b1;
    cnt_clr = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    wrap    = 1'b0;
    case (state)
      CLEAR: begin
        busy    = 1'b1;
        cnt_clr = 1'b1;
      end
      RUN_UP: begin
        busy = 1'b1;
        if (!stop && step_due) begin
          if (!at_limit) begin
            cnt_en = 1'b1;
          end else if (mode_q == MODE_REPEAT) begin
            cnt_clr = 1'b1;
            wrap    = 1'b1;
          end
        end
      end
      RUN_DOWN: begin
        busy   = 1'b1;
        cnt_up = 1'b0;
        if (!stop && step_due && !at_zero) begin
          cnt_en = 1'b1;
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter BITS, default 4, SHALL set the counter width; parameter DIVW, default 8, SHALL set the prescaler width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, SHALL be asynchronous and active-low.
REQ-004 start  input  1  request to begin a run; sampled only in IDLE.
REQ-005 stop  input  1  request to abort a run; sampled only in run states.
REQ-006 mode  input  2  run mode: 00 one-shot up, 01 repeat up, 10 bounce, 11 one-shot bounce.
REQ-007 limit  input  BITS  terminal count.
REQ-008 div  input  DIVW  prescaler: one step opportunity every div+1 cycles.
REQ-009 cnt_val  input  BITS  current value fed back from the counter.
REQ-010 cnt_en  output  1  step the counter this cycle.
REQ-011 cnt_up  output  1  direction: 1 up, 0 down; drives the counter's select.
REQ-012 cnt_clr  output  1  synchronous clear; drives the counter's active-high rst.
REQ-013 busy  output  1  high in CLEAR, RUN_UP, RUN_DOWN.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 wrap  output  1  one-cycle pulse on each mode-01 wrap.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, RUN_UP, RUN_DOWN, DONE.
REQ-017 IDLE: start=1 -> CLEAR, latching mode, limit, div; stop ignored; start+stop together -> CLEAR.
REQ-018 CLEAR: cnt_clr=1 for exactly one cycle, prescaler loaded with latched div -> RUN_UP.
REQ-019 step_due SHALL be 1 when the prescaler is 0; the prescaler reloads div on step_due, else decrements; it holds div outside run states.
REQ-020 RUN_UP, step_due, cnt_val!=limit: cnt_en=1, cnt_up=1.
REQ-021 RUN_UP, step_due, cnt_val==limit: mode 00 -> DONE; 01 -> cnt_clr=1, wrap=1, stay; 10/11 -> RUN_DOWN; no cnt_en that cycle.
REQ-022 RUN_DOWN, step_due, cnt_val!=0: cnt_en=1, cnt_up=0.
REQ-023 RUN_DOWN, step_due, cnt_val==0: mode 10 -> RUN_UP; mode 11 -> DONE; no cnt_en that cycle.
REQ-024 DONE: done=1 for one cycle -> IDLE; counter value held.
REQ-025 stop=1 in any run state SHALL force IDLE next cycle, suppress cnt_en/cnt_clr that cycle, hold the count, and not pulse done.
REQ-026 cnt_en, cnt_up, cnt_clr, done, wrap SHALL be decoded from registered state, the prescaler and cnt_val only; start has no combinational path to them.
REQ-027 cnt_en and cnt_clr SHALL never be high together; cnt_up SHALL be 1 outside RUN_DOWN.
REQ-028 limit=0: mode 00 done at first step_due; 01 wraps every step_due; 10 reverses every step_due; 11 reverses once then DONE.
REQ-029 Changes to mode/limit/div during a run SHALL have no effect until the next start.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, prescaler and latched registers to 0, cnt_en=cnt_clr=busy=done=wrap=0, cnt_up=1, including mid-run.
REQ-031 After rst_n release the first accepted start SHALL be the first start sampled high in IDLE.

Structure
REQ-032 Package counter_ctrl_pkg SHALL hold the state enum and the mode encodings (MODE_ONESHOT, MODE_REPEAT, MODE_BOUNCE, MODE_BOUNCE_ONCE).
REQ-033 The prescaler SHALL be one sub-module, counter_tick_gen (inputs clk, rst_n, load, div; output step_due).
REQ-034 The counter itself SHALL remain a separate instance outside counter_ctrl.

Verification
REQ-035 mode=00, limit=5, div=0, start: cnt_clr 1 cycle, then cnt_en for 5 consecutive cycles, count 0..5, done 1 cycle later, busy low.
REQ-036 mode=01, limit=3, div=2: cnt_en every 3rd cycle, count 0,1,2,3,0; wrap pulses with cnt_clr at each 3->0.
REQ-037 mode=11, limit=2, div=0: count 0,1,2 then cnt_up=0, 2,1,0, then done; total steps 4.
REQ-038 mode=10, limit=4, stop asserted at count 3 while descending: IDLE next cycle, count stays 3, no done.
REQ-039 rst_n pulsed low mid-run (mode 00, limit 15, count 7): outputs zero asynchronously, IDLE; new start restarts from cnt_clr.
REQ-040 limit=0 in each mode and start held high continuously: matches REQ-028; start ignored while busy.
